// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared constants and pulse-width helper for the servo PWM driver
package servo_pkg;

    localparam int POS_W  = 8;
    localparam int NUM_CH = 4;
    localparam int US_W   = 15;

    localparam int CH_X = 0;
    localparam int CH_Y = 1;
    localparam int CH_Z = 2;
    localparam int CH_G = 3;

    // Pulse width in microseconds for a position code, 15-bit unsigned
    function automatic logic [US_W-1:0] pulse_us(
        input logic [POS_W-1:0] code,
        input int               min_us,
        input int               step_us
    );
        logic [US_W-1:0] width;
        width = US_W'(min_us) + US_W'(code) * US_W'(step_us);
        return width;
    endfunction

endpackage

// File: rtl/servo_channel.sv
// rtl/servo_channel.sv - one servo joint: target latch, slew limiter, pulse compare
module servo_channel
    import servo_pkg::*;
#(
    parameter int MIN_US   = 1000,
    parameter int STEP_US  = 4,
    parameter int SLEW     = 4,
    parameter int INIT_POS = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_end,
    input  logic             en_q,
    input  logic [US_W-1:0]  us_cnt,
    input  logic [POS_W-1:0] target,
    output logic             pwm,
    output logic             at_target
);

    localparam logic [POS_W-1:0] INIT_CODE = POS_W'(INIT_POS);
    localparam logic [POS_W-1:0] SLEW_CODE = POS_W'(SLEW);
    localparam logic [POS_W:0]   SLEW_MAG  = (POS_W+1)'(SLEW);

    logic [POS_W-1:0] tgt;
    logic [POS_W-1:0] cur;
    logic [POS_W-1:0] cur_next;
    logic [POS_W:0]   diff;
    logic [POS_W:0]   mag;

    // Next position: one bounded step toward the sampled input; 9-bit difference keeps the sign
    always_comb begin
        diff     = {1'b0, target} - {1'b0, cur};
        mag      = diff[POS_W] ? (~diff + 1'b1) : diff;
        cur_next = target;
        if (SLEW != 0 && mag > SLEW_MAG) begin
            if (diff[POS_W]) begin
                cur_next = cur - SLEW_CODE;
            end else begin
                cur_next = cur + SLEW_CODE;
            end
        end
    end

    // Target and position only move on the frame-end strobe so a pulse is never torn
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt <= INIT_CODE;
            cur <= INIT_CODE;
        end else if (frame_end) begin
            tgt <= target;
            cur <= cur_next;
        end
    end

    // Registered pulse compare and settled flag
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm       <= 1'b0;
            at_target <= 1'b1;
        end else begin
            pwm       <= en_q && (us_cnt < pulse_us(cur, MIN_US, STEP_US));
            at_target <= (cur == tgt);
        end
    end

endmodule

// File: rtl/servo_pwm_driver.sv
// rtl/servo_pwm_driver.sv - four-channel 50 Hz servo PWM generator with shared timebase
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int TICK_DIV = 50,
    parameter int FRAME_US = 20000,
    parameter int MIN_US   = 1000,
    parameter int STEP_US  = 4,
    parameter int SLEW     = 4,
    parameter int INIT_POS = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [POS_W-1:0]  dx,
    input  logic [POS_W-1:0]  dy,
    input  logic [POS_W-1:0]  dz,
    input  logic [POS_W-1:0]  dg,
    input  logic              enable,
    output logic [NUM_CH-1:0] pwm,
    output logic              frame_sync,
    output logic [NUM_CH-1:0] at_target
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [US_W-1:0]  US_LAST  = US_W'(FRAME_US - 1);

    // The widest pulse (code 255) must end before the frame does
    if (MIN_US + ((1 << POS_W) - 1) * STEP_US >= FRAME_US) begin : g_bad_params
        $fatal(1, "servo_pwm_driver: longest pulse does not fit inside the frame");
    end

    logic [PRE_W-1:0]              pre;
    logic [US_W-1:0]               us_cnt;
    logic                          pre_wrap;
    logic                          frame_end;
    logic                          en_q;
    logic [NUM_CH-1:0][POS_W-1:0]  targets;

    assign pre_wrap  = (pre == PRE_LAST);
    assign frame_end = pre_wrap && (us_cnt == US_LAST);

    assign targets[CH_X] = dx;
    assign targets[CH_Y] = dy;
    assign targets[CH_Z] = dz;
    assign targets[CH_G] = dg;

    // Prescaler and microsecond counter; us_cnt wraps at the end of each frame
    always_ff @(posedge clk) begin
        if (rst) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (pre_wrap) begin
            pre    <= '0;
            us_cnt <= (us_cnt == US_LAST) ? '0 : us_cnt + US_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Frame start marker (aligned with the registered pwm rise) and frame-sampled enable
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_sync <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            frame_sync <= (pre == '0) && (us_cnt == '0);
            if (frame_end) begin
                en_q <= enable;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_channel #(
            .MIN_US   (MIN_US),
            .STEP_US  (STEP_US),
            .SLEW     (SLEW),
            .INIT_POS (INIT_POS)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .frame_end (frame_end),
            .en_q      (en_q),
            .us_cnt    (us_cnt),
            .target    (targets[i]),
            .pwm       (pwm[i]),
            .at_target (at_target[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb/tb_servo_pwm_driver.sv - self-checking bench for servo_pwm_driver
`timescale 1ns/1ps
module tb_servo_pwm_driver;

    localparam int FRAME_CYC = 6000;
    localparam int SL_FRAME  = 400;

    logic       clk;
    logic       rst;
    logic [7:0] dx, dy, dz, dg;
    logic       enable;

    logic [3:0] pwm, at_target;
    logic       frame_sync;
    logic [3:0] pwm_ns, at_target_ns;
    logic       frame_sync_ns;
    logic [3:0] pwm_sl, at_target_sl;
    logic       frame_sync_sl;

    servo_pwm_driver #(
        .TICK_DIV(2), .FRAME_US(3000), .MIN_US(1000), .STEP_US(4), .SLEW(4), .INIT_POS(128)
    ) dut (
        .clk(clk), .rst(rst), .dx(dx), .dy(dy), .dz(dz), .dg(dg), .enable(enable),
        .pwm(pwm), .frame_sync(frame_sync), .at_target(at_target)
    );

    servo_pwm_driver #(
        .TICK_DIV(2), .FRAME_US(3000), .MIN_US(1000), .STEP_US(4), .SLEW(0), .INIT_POS(128)
    ) dut_ns (
        .clk(clk), .rst(rst), .dx(dx), .dy(dy), .dz(dz), .dg(dg), .enable(enable),
        .pwm(pwm_ns), .frame_sync(frame_sync_ns), .at_target(at_target_ns)
    );

    servo_pwm_driver #(
        .TICK_DIV(1), .FRAME_US(400), .MIN_US(100), .STEP_US(1), .SLEW(4), .INIT_POS(128)
    ) dut_sl (
        .clk(clk), .rst(rst), .dx(dx), .dy(dy), .dz(dz), .dg(dg), .enable(enable),
        .pwm(pwm_sl), .frame_sync(frame_sync_sl), .at_target(at_target_sl)
    );

    typedef struct {
        int              act_at;
        logic [7:0]      dx, dy, dz, dg;
        logic            en;
        logic            glitch;
        logic [3:0][15:0] w_dut;
        logic [3:0][15:0] w_ns;
        logic [3:0]      at_dut;
        logic [3:0]      at_ns;
    } vec_t;

    vec_t v [5];

    int         n_tests = 0;
    int         n_fail  = 0;
    int         sync_wait;
    int         sync_cnt;
    int         cnt_dut [4];
    int         cnt_ns  [4];
    logic [3:0] first_pwm;
    logic [3:0] at_first_dut, at_first_ns;
    logic       at_moved;
    int         sl_wait;
    int         sl_width;
    logic       sl_at0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_sync_main(input int limit);
        sync_wait = 0;
        do begin
            @(negedge clk);
            sync_wait++;
        end while (!frame_sync && sync_wait < limit);
    endtask

    task automatic measure_frame();
        wait_sync_main(FRAME_CYC + 1000);
        for (int c = 0; c < 4; c++) begin
            cnt_dut[c] = 0;
            cnt_ns[c]  = 0;
        end
        first_pwm    = pwm;
        at_first_dut = at_target;
        at_first_ns  = at_target_ns;
        at_moved     = 1'b0;
        sync_cnt     = 0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (i > 0) @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                cnt_dut[c] += int'(pwm[c]);
                cnt_ns[c]  += int'(pwm_ns[c]);
            end
            if (frame_sync) sync_cnt++;
            if (at_target != at_first_dut || at_target_ns != at_first_ns) at_moved = 1'b1;
        end
    endtask

    task automatic measure_sl();
        sl_wait = 0;
        do begin
            @(negedge clk);
            sl_wait++;
        end while (!frame_sync_sl && sl_wait < SL_FRAME + 100);
        sl_width = 0;
        sl_at0   = at_target_sl[0];
        for (int i = 0; i < SL_FRAME; i++) begin
            if (i > 0) @(negedge clk);
            sl_width += int'(pwm_sl[0]);
        end
    endtask

    initial begin
        // frame-by-frame vectors for the main instances; widths in clk cycles, order {g,z,y,x}
        v[0] = '{2000, 8'd128, 8'd128, 8'd128, 8'd10, 1'b1, 1'b1,
                 {4{16'd0}}, {4{16'd0}}, 4'b1111, 4'b1111};
        v[1] = '{4000, 8'd128, 8'd0, 8'd255, 8'd128, 1'b1, 1'b0,
                 {16'd3024, 16'd3024, 16'd3024, 16'd3024},
                 {16'd3024, 16'd3024, 16'd3024, 16'd3024}, 4'b1111, 4'b1111};
        v[2] = '{1000, 8'd128, 8'd0, 8'd255, 8'd128, 1'b0, 1'b0,
                 {16'd3024, 16'd3056, 16'd2992, 16'd3024},
                 {16'd3024, 16'd4040, 16'd2000, 16'd3024}, 4'b1001, 4'b1111};
        v[3] = '{3000, 8'd128, 8'd0, 8'd255, 8'd128, 1'b1, 1'b0,
                 {4{16'd0}}, {4{16'd0}}, 4'b1001, 4'b1111};
        v[4] = '{100, 8'd128, 8'd0, 8'd255, 8'd128, 1'b1, 1'b0,
                 {16'd3024, 16'd3120, 16'd2928, 16'd3024},
                 {16'd3024, 16'd4040, 16'd2000, 16'd3024}, 4'b1001, 4'b1111};

        rst = 1'b1; enable = 1'b1;
        dx = 8'd128; dy = 8'd128; dz = 8'd128; dg = 8'd128;
        repeat (5) @(negedge clk);
        check("reset_pwm", int'(pwm), 0);
        check("reset_frame_sync", int'(frame_sync), 0);
        check("reset_at_target", int'(at_target), 15);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) begin
            fork
                measure_frame();
                begin
                    repeat (v[k].act_at) @(negedge clk);
                    dx = v[k].dx; dy = v[k].dy; dz = v[k].dz; dg = v[k].dg;
                    enable = v[k].en;
                    if (v[k].glitch) begin
                        repeat (100) @(negedge clk);
                        dg = 8'd128;
                    end
                end
            join
            check($sformatf("f%0d_sync_wait", k), sync_wait, 1);
            check($sformatf("f%0d_sync_count", k), sync_cnt, 1);
            check($sformatf("f%0d_at_dut", k), int'(at_first_dut), int'(v[k].at_dut));
            check($sformatf("f%0d_at_ns", k), int'(at_first_ns), int'(v[k].at_ns));
            check($sformatf("f%0d_at_stable", k), int'(at_moved), 0);
            for (int c = 0; c < 4; c++) begin
                check($sformatf("f%0d_width_dut_ch%0d", k, c), cnt_dut[c], int'(v[k].w_dut[c]));
                check($sformatf("f%0d_width_ns_ch%0d", k, c), cnt_ns[c], int'(v[k].w_ns[c]));
                check($sformatf("f%0d_rise_with_sync_ch%0d", k, c), int'(first_pwm[c]),
                      int'(v[k].w_dut[c] != 16'd0));
            end
        end

        // reset in the middle of a pulse
        wait_sync_main(FRAME_CYC + 1000);
        check("rstmid_sync_wait", sync_wait, 1);
        repeat (1400) @(negedge clk);
        check("rstmid_pwm_before", int'(pwm), 15);
        check("rstmid_pwm_ns_before", int'(pwm_ns), 15);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_pwm_cleared", int'(pwm), 0);
        check("rstmid_pwm_ns_cleared", int'(pwm_ns), 0);
        check("rstmid_at_target", int'(at_target), 15);
        repeat (2) @(negedge clk);
        check("rstmid_sync_in_reset", int'(frame_sync), 0);
        rst = 1'b0;
        dx  = 8'd200;
        @(negedge clk);
        check("rstmid_sync_after_release", int'(frame_sync), 1);
        check("rstmid_sync_sl_after_release", int'(frame_sync_sl), 1);
        @(negedge clk);
        check("rstmid_sync_one_cycle", int'(frame_sync), 0);

        // slew 128 -> 200 in steps of 4 on the short-frame instance (width = 100 + code cycles)
        for (int k = 1; k <= 19; k++) begin
            int exp_cur;
            measure_sl();
            exp_cur = (128 + 4 * k > 200) ? 200 : 128 + 4 * k;
            if (k > 1) check($sformatf("slew_f%0d_sync_wait", k), sl_wait, 1);
            check($sformatf("slew_f%0d_width", k), sl_width, 100 + exp_cur);
            check($sformatf("slew_f%0d_at_target_x", k), int'(sl_at0), int'(k >= 18));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
